// File: rtl/t5_pkg.sv
// Shared constants and types for the t5 pipeline: opcodes, funct3 codes, LSU state encoding.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Undefined funct3 codes fall through to word size.
  function automatic lsu_size_t fn3_size(input logic [2:0] fn3);
    case (fn3)
      FN3_B, FN3_BU: fn3_size = SZ_B;
      FN3_H, FN3_HU: fn3_size = SZ_H;
      default:       fn3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Combinational byte-lane logic: store/load lane enables, misalign detect, load extract and extend.
module t5_lsu_align
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fn3,
  input  logic [1:0]      off,
  output logic [3:0]      sel,
  output logic            mis,
  input  logic [2:0]      ld_fn3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_raw,
  output logic [XLEN-1:0] ld_dat
);

  lsu_size_t       size;
  lsu_size_t       ld_size;
  logic [XLEN-1:0] lane;
  logic            sgn;

  assign size    = fn3_size(fn3);
  assign ld_size = fn3_size(ld_fn3);
  assign lane    = ld_raw >> {ld_off, 3'b000};
  assign sgn     = ~ld_fn3[2];

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    sel = 4'b1111;
    mis = 1'b0;
    case (size)
      SZ_B: sel = 4'b0001 << off;
      SZ_H: begin
        sel = off[1] ? 4'b1100 : 4'b0011;
        mis = off[0];
      end
      default: mis = |off;
    endcase
  end

  always_comb begin
    ld_dat = lane;
    case (ld_size)
      SZ_B:    ld_dat = {{(XLEN-8){lane[7] & sgn}}, lane[7:0]};
      SZ_H:    ld_dat = {{(XLEN-16){lane[15] & sgn}}, lane[15:0]};
      default: ld_dat = lane;
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// Memory-stage load/store unit: one registered data-bus cycle per load/store, pipeline hold while busy.
module t5_lsu
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            sena,
  input  logic [XLEN-1:0] xbpc,
  input  logic [XLEN-1:0] xdat,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  output logic [XLEN-1:0] dwb_adr_o,
  output logic [XLEN-1:0] dwb_dat_o,
  output logic [3:0]      dwb_sel_o,
  output logic            dwb_we_o,
  output logic            dwb_stb_o,
  output logic            dwb_cyc_o,
  input  logic [XLEN-1:0] dwb_dat_i,
  input  logic            dwb_ack_i,
  output logic            sstall,
  output logic [XLEN-1:0] mdat,
  output logic            mlod,
  output logic            mmis
);

  lsu_state_t      state;
  logic            is_load;
  logic            is_store;
  logic            memop;
  logic [3:0]      sel_c;
  logic            mis_c;
  logic [1:0]      off_q;
  logic [2:0]      fn3_q;
  logic [XLEN-1:0] ld_dat;

  assign is_load  = (xopc == OPC_LOAD);
  assign is_store = (xopc == OPC_STORE);
  assign memop    = is_load | is_store;

  // Lane/misalign decode uses the live execute address; extract uses the address latched at issue.
  t5_lsu_align #(.XLEN(XLEN)) u_align (
    .fn3    (xfn3),
    .off    (xbpc[1:0]),
    .sel    (sel_c),
    .mis    (mis_c),
    .ld_fn3 (fn3_q),
    .ld_off (off_q),
    .ld_raw (dwb_dat_i),
    .ld_dat (ld_dat)
  );

  assign dwb_cyc_o = dwb_stb_o;
  assign sstall    = ((state == LSU_IDLE) & memop) | (state == LSU_REQ);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= LSU_IDLE;
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      dwb_sel_o <= '0;
      dwb_we_o  <= 1'b0;
      dwb_stb_o <= 1'b0;
      off_q     <= '0;
      fn3_q     <= '0;
      mdat      <= '0;
      mlod      <= 1'b0;
      mmis      <= 1'b0;
    end else begin
      mlod <= 1'b0;
      mmis <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (memop) begin
            if (mis_c) begin
              mmis  <= 1'b1;
              state <= LSU_DONE;
            end else begin
              dwb_adr_o <= {xbpc[XLEN-1:2], 2'b00};
              dwb_dat_o <= xdat;
              dwb_sel_o <= sel_c;
              dwb_we_o  <= is_store;
              dwb_stb_o <= 1'b1;
              off_q     <= xbpc[1:0];
              fn3_q     <= xfn3;
              state     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dwb_ack_i) begin
            dwb_stb_o <= 1'b0;
            state     <= LSU_DONE;
            if (!dwb_we_o) begin
              mdat <= ld_dat;
              mlod <= 1'b1;
            end
          end
        end
        LSU_DONE: begin
          // Wait for the pipeline to advance so a held instruction is not issued twice.
          if (sena) state <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_lsu.sv
// Directed bench for t5_lsu: loads, stores, misalign, held pipeline, reset during a bus cycle.
module tb_t5_lsu;
  import t5_pkg::*;

  localparam logic [4:0] OPC_NOP = 5'b00100;

  logic        sclk;
  logic        srst_n;
  logic        sena;
  logic [31:0] xbpc;
  logic [31:0] xdat;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_stb_o;
  logic        dwb_cyc_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic        sstall;
  logic [31:0] mdat;
  logic        mlod;
  logic        mmis;

  int vectors;
  int miscompares;

  int          stalls;
  int          stb_n;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  t5_lsu #(.XLEN(32)) dut (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .sena      (sena),
    .xbpc      (xbpc),
    .xdat      (xdat),
    .xopc      (xopc),
    .xfn3      (xfn3),
    .dwb_adr_o (dwb_adr_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_we_o  (dwb_we_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_ack_i (dwb_ack_i),
    .sstall    (sstall),
    .mdat      (mdat),
    .mlod      (mlod),
    .mmis      (mmis)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic set_op(input logic [4:0] opc, input logic [2:0] fn3,
                        input logic [31:0] adr, input logic [31:0] dat);
    xopc = opc;
    xfn3 = fn3;
    xbpc = adr;
    xdat = dat;
  endtask

  // Acts as the slave for one access: acks after `waits` strobe cycles, counts stall and strobe cycles.
  task automatic bus_op(input int waits, input logic [31:0] rdat);
    int w;
    w      = 0;
    stalls = 0;
    stb_n  = 0;
    #1;
    for (int i = 0; i < 20 && sstall; i++) begin
      stalls++;
      if (dwb_stb_o) begin
        stb_n++;
        cap_adr = dwb_adr_o;
        cap_dat = dwb_dat_o;
        cap_sel = dwb_sel_o;
        cap_we  = dwb_we_o;
        if (w == waits) begin
          dwb_ack_i = 1'b1;
          dwb_dat_i = rdat;
        end
        w++;
      end
      tick();
      dwb_ack_i = 1'b0;
      dwb_dat_i = 32'h0;
      #1;
    end
    check("bus_op_timeout", {31'b0, sstall}, 32'd0);
  endtask

  task automatic retire();
    xopc = OPC_NOP;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    srst_n      = 1'b0;
    sena        = 1'b1;
    dwb_ack_i   = 1'b0;
    dwb_dat_i   = 32'h0;
    set_op(OPC_NOP, FN3_W, 32'h0, 32'h0);
    #12;
    check("rst_stb",    {31'b0, dwb_stb_o}, 32'd0);
    check("rst_cyc",    {31'b0, dwb_cyc_o}, 32'd0);
    check("rst_we",     {31'b0, dwb_we_o},  32'd0);
    check("rst_sel",    {28'b0, dwb_sel_o}, 32'd0);
    check("rst_adr",    dwb_adr_o,          32'd0);
    check("rst_mdat",   mdat,               32'd0);
    check("rst_mlod",   {31'b0, mlod},      32'd0);
    check("rst_mmis",   {31'b0, mmis},      32'd0);
    check("rst_sstall", {31'b0, sstall},    32'd0);
    tick();
    srst_n = 1'b1;
    tick();

    // LW 0x100, one wait state
    set_op(OPC_LOAD, FN3_W, 32'h100, 32'h0);
    bus_op(1, 32'hDEADBEEF);
    check("lw_stalls", stalls,              32'd3);
    check("lw_stb_n",  stb_n,               32'd2);
    check("lw_sel",    {28'b0, cap_sel},    32'hF);
    check("lw_we",     {31'b0, cap_we},     32'd0);
    check("lw_adr",    cap_adr,             32'h100);
    check("lw_mdat",   mdat,                32'hDEADBEEF);
    check("lw_mlod",   {31'b0, mlod},       32'd1);
    check("lw_mmis",   {31'b0, mmis},       32'd0);
    check("lw_cyc_off",{31'b0, dwb_cyc_o},  32'd0);
    retire();
    check("lw_mlod_pulse", {31'b0, mlod}, 32'd0);
    check("lw_mdat_hold",  mdat,          32'hDEADBEEF);

    // LB 0x103 sign-extends, LBU zero-extends
    set_op(OPC_LOAD, FN3_B, 32'h103, 32'h0);
    bus_op(0, 32'h80FFFF7F);
    check("lb_stalls", stalls,           32'd2);
    check("lb_sel",    {28'b0, cap_sel}, 32'b1000);
    check("lb_adr",    cap_adr,          32'h100);
    check("lb_mdat",   mdat,             32'hFFFFFF80);
    retire();
    set_op(OPC_LOAD, FN3_BU, 32'h103, 32'h0);
    bus_op(0, 32'h80FFFF7F);
    check("lbu_mdat",  mdat,             32'h00000080);
    retire();

    // LH 0x102 upper half sign-extends
    set_op(OPC_LOAD, FN3_H, 32'h102, 32'h0);
    bus_op(0, 32'h80FFFF7F);
    check("lh_sel",    {28'b0, cap_sel}, 32'b1100);
    check("lh_mdat",   mdat,             32'hFFFF80FF);
    retire();
    set_op(OPC_LOAD, FN3_HU, 32'h100, 32'h0);
    bus_op(0, 32'h80FF8001);
    check("lhu_sel",   {28'b0, cap_sel}, 32'b0011);
    check("lhu_mdat",  mdat,             32'h00008001);
    retire();

    // SB 0x201, zero-wait
    set_op(OPC_STORE, FN3_B, 32'h201, 32'h5A5A5A5A);
    bus_op(0, 32'h11111111);
    check("sb_stalls", stalls,           32'd2);
    check("sb_stb_n",  stb_n,            32'd1);
    check("sb_we",     {31'b0, cap_we},  32'd1);
    check("sb_sel",    {28'b0, cap_sel}, 32'b0010);
    check("sb_adr",    cap_adr,          32'h200);
    check("sb_dat",    cap_dat,          32'h5A5A5A5A);
    check("sb_mlod",   {31'b0, mlod},    32'd0);
    check("sb_mdat",   mdat,             32'h00008001);
    retire();

    // LW 0x102 misaligned: no bus cycle
    set_op(OPC_LOAD, FN3_W, 32'h102, 32'h0);
    bus_op(0, 32'h22222222);
    check("mis_stalls", stalls,        32'd1);
    check("mis_stb_n",  stb_n,         32'd0);
    check("mis_mmis",   {31'b0, mmis}, 32'd1);
    check("mis_mlod",   {31'b0, mlod}, 32'd0);
    check("mis_mdat",   mdat,          32'h00008001);
    retire();
    check("mis_pulse",  {31'b0, mmis}, 32'd0);

    // Undefined funct3 behaves as word
    set_op(OPC_LOAD, 3'b011, 32'h40, 32'h0);
    bus_op(0, 32'h0BADF00D);
    check("fn011_sel",  {28'b0, cap_sel}, 32'hF);
    check("fn011_mdat", mdat,             32'h0BADF00D);
    retire();
    set_op(OPC_LOAD, 3'b110, 32'h41, 32'h0);
    bus_op(0, 32'h0);
    check("fn110_mmis", {31'b0, mmis}, 32'd1);
    check("fn110_stb",  stb_n,         32'd0);
    retire();

    // LW issued with sena=0 and held in DONE
    sena = 1'b0;
    set_op(OPC_LOAD, FN3_W, 32'h300, 32'h0);
    bus_op(0, 32'h12345678);
    check("hold_stb_n", stb_n, 32'd1);
    check("hold_mdat",  mdat,  32'h12345678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stb",    {31'b0, dwb_stb_o}, 32'd0);
      check("hold_sstall", {31'b0, sstall},    32'd0);
    end
    sena = 1'b1;
    tick();
    set_op(OPC_STORE, FN3_H, 32'h306, 32'hBEEFBEEF);
    bus_op(0, 32'h0);
    check("next_stb_n", stb_n,            32'd1);
    check("next_sel",   {28'b0, cap_sel}, 32'b1100);
    check("next_we",    {31'b0, cap_we},  32'd1);
    check("next_adr",   cap_adr,          32'h304);
    retire();

    // Reset while a load is pending in REQ
    set_op(OPC_LOAD, FN3_W, 32'h500, 32'h0);
    tick();
    check("rreq_stb", {31'b0, dwb_stb_o}, 32'd1);
    srst_n    = 1'b0;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'hAAAA5555;
    #1;
    check("rreq_stb_drop", {31'b0, dwb_stb_o}, 32'd0);
    check("rreq_cyc_drop", {31'b0, dwb_cyc_o}, 32'd0);
    check("rreq_mdat",     mdat,               32'd0);
    tick();
    srst_n = 1'b1;
    xopc   = OPC_NOP;
    tick();
    dwb_ack_i = 1'b0;
    #1;
    check("late_ack_mlod",   {31'b0, mlod},      32'd0);
    check("late_ack_mdat",   mdat,               32'd0);
    check("late_ack_stb",    {31'b0, dwb_stb_o}, 32'd0);
    check("late_ack_sstall", {31'b0, sstall},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
